// File: rtl/text_sched_pkg.sv
// text_sched_pkg: shared types and widths for the text overlay scheduler.
//   phase_e   - sequencer phase, encoding is visible on the phase_o debug port
//   PHASE_W   - phase encoding width
//   OFFSET_W  - vertical offset width (offsets up to 511 px)
//   max_i     - integer max helper, used to size the frame counter
package text_sched_pkg;

  localparam int PHASE_W  = 3;
  localparam int OFFSET_W = 9;

  typedef enum logic [PHASE_W-1:0] {
    PH_BLANK     = 3'd0,
    PH_SLIDE_IN  = 3'd1,
    PH_HOLD      = 3'd2,
    PH_BLINK     = 3'd3,
    PH_SLIDE_OUT = 3'd4
  } phase_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/text_sched_timer.sv
// text_sched_timer: frame counter for the overlay sequencer.
// Ports:
//   clk_i   pixel clock
//   rst_i   synchronous active-high reset (count -> 0)
//   clr_i   synchronous clear, wins over en_i
//   en_i    count one accepted frame
//   tc_i    terminal count to compare against
//   cnt_o   current count
//   done_o  cnt_o == tc_i (combinational)
module text_sched_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/text_overlay_scheduler.sv
// text_overlay_scheduler: frame-rate sequencer for bitmap text overlays.
// Steps the selected text through BLANK -> SLIDE_IN -> HOLD -> [BLINK] ->
// SLIDE_OUT, then advances to the next text. All state moves only on an
// accepted frame (frame_start_i & ~pause_i), i.e. inside vblank.
// Build option: define TEXT_SCHED_BLINK_EN to include the BLINK phase;
// without it HOLD goes straight to SLIDE_OUT and BLINK_FRAMES is unused.
// Ports:
//   clk_i             pixel clock
//   rst_i             synchronous active-high reset
//   frame_start_i     one-cycle pulse at start of vblank
//   pause_i           level, drops frame_start_i while high
//   text_active_i     per-generator pixel hit
//   text_sel_o        index of current text
//   y_offset_o        vertical offset added to y by the top
//   phase_o           current phase encoding
//   overlay_active_o  final overlay pixel (combinational, zero latency)
module text_overlay_scheduler
  import text_sched_pkg::*;
#(
  parameter int NUM_TEXTS    = 4,
  parameter int BLANK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 32,
  parameter int SLIDE_DIST   = 160,
  parameter int SLIDE_STEP   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         frame_start_i,
  input  logic                         pause_i,
  input  logic [NUM_TEXTS-1:0]         text_active_i,
  output logic [$clog2(NUM_TEXTS)-1:0] text_sel_o,
  output logic [OFFSET_W-1:0]          y_offset_o,
  output logic [PHASE_W-1:0]           phase_o,
  output logic                         overlay_active_o
);

  localparam int SEL_W = $clog2(NUM_TEXTS);
  localparam int MAXF  = max_i(max_i(BLANK_FRAMES, HOLD_FRAMES), BLINK_FRAMES);
  // at least 4 bits so the blink bit (cnt[3]) always exists
  localparam int CNT_W = max_i($clog2(MAXF + 1), 4);

  phase_e              state_q, state_d;
  logic [OFFSET_W-1:0] y_offset_q, y_offset_d;
  logic [SEL_W-1:0]    text_sel_q, text_sel_d;

  logic             accept;
  logic             visible;
  logic             cnt_clr, cnt_en, cnt_done;
  logic [CNT_W-1:0] cnt_tc, frame_cnt;
  logic             cnt_unused;

  assign accept = frame_start_i & ~pause_i;

  text_sched_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_i   (cnt_tc),
    .cnt_o  (frame_cnt),
    .done_o (cnt_done)
  );

  // only cnt[3] is read here, and only in the blink build
  assign cnt_unused = ^frame_cnt;

  always_comb begin
    state_d    = state_q;
    y_offset_d = y_offset_q;
    text_sel_d = text_sel_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_tc     = '0;
    visible    = 1'b0;
    case (state_q)
      PH_BLANK: begin
        cnt_tc = CNT_W'(BLANK_FRAMES - 1);
        if (accept) begin
          if (cnt_done) begin
            state_d    = PH_SLIDE_IN;
            y_offset_d = OFFSET_W'(SLIDE_DIST);
            cnt_clr    = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      PH_SLIDE_IN: begin
        visible = 1'b1;
        if (accept) begin
          // saturate at 0 instead of wrapping below zero
          if (y_offset_q <= OFFSET_W'(SLIDE_STEP)) begin
            y_offset_d = '0;
            state_d    = PH_HOLD;
            cnt_clr    = 1'b1;
          end else begin
            y_offset_d = y_offset_q - OFFSET_W'(SLIDE_STEP);
          end
        end
      end
      PH_HOLD: begin
        visible = 1'b1;
        cnt_tc  = CNT_W'(HOLD_FRAMES - 1);
        if (accept) begin
          y_offset_d = '0;
          if (cnt_done) begin
`ifdef TEXT_SCHED_BLINK_EN
            state_d = PH_BLINK;
`else
            state_d = PH_SLIDE_OUT;
`endif
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
`ifdef TEXT_SCHED_BLINK_EN
      PH_BLINK: begin
        // 8 frames on, 8 off, starting visible
        visible = ~frame_cnt[3];
        cnt_tc  = CNT_W'(BLINK_FRAMES - 1);
        if (accept) begin
          if (cnt_done) begin
            state_d = PH_SLIDE_OUT;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
`endif
      PH_SLIDE_OUT: begin
        visible = 1'b1;
        if (accept) begin
          if (y_offset_q >= OFFSET_W'(SLIDE_DIST - SLIDE_STEP)) begin
            y_offset_d = OFFSET_W'(SLIDE_DIST);
            state_d    = PH_BLANK;
            text_sel_d = (text_sel_q == SEL_W'(NUM_TEXTS - 1)) ? '0
                                                               : text_sel_q + 1'b1;
          end else begin
            y_offset_d = y_offset_q + OFFSET_W'(SLIDE_STEP);
          end
        end
      end
      default: state_d = PH_BLANK;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PH_BLANK;
      y_offset_q <= OFFSET_W'(SLIDE_DIST);
      text_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      y_offset_q <= y_offset_d;
      text_sel_q <= text_sel_d;
    end
  end

  assign text_sel_o       = text_sel_q;
  assign y_offset_o       = y_offset_q;
  assign phase_o          = state_q;
  assign overlay_active_o = visible & text_active_i[text_sel_q];

endmodule

// File: doc/text_overlay_scheduler.md
# text_overlay_scheduler

Frame-rate sequencer for the demo's bitmap text overlays. It selects one of `NUM_TEXTS` combinational text generators at a time and steps it through blank, slide-in, hold, blink and slide-out phases. It drives the vertical offset that the top adds to `y` before feeding the generators, and gates the selected generator's pixel hit into the final `overlay_active`. It sits between the VGA timing generator (frame pulse) and the text generator instances in the top level.

## Interface
Parameters:
- `NUM_TEXTS`, 4: number of text generators; ≥2.
- `BLANK_FRAMES`, 30: frames with nothing shown between texts.
- `HOLD_FRAMES`, 120: frames the text is static at final position.
- `BLINK_FRAMES`, 32: frames of blinking after hold.
- `SLIDE_DIST`, 160: start/end vertical offset in pixels; must be < 512.
- `SLIDE_STEP`, 2: offset change per frame during slides; 1..SLIDE_DIST.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse at start of vertical blank.
- `pause`  in  1  level; while high, `frame_start` is ignored.
- `text_active`  in  NUM_TEXTS  per-generator pixel hit for the current (x, y+offset).
- `text_sel`  out  $clog2(NUM_TEXTS)  index of the current text.
- `y_offset`  out  9  unsigned offset added to `y` by the top.
- `phase`  out  3  current state encoding (debug/colour selection).
- `overlay_active`  out  1  final overlay pixel.

## Operation
- States (in `phase` encoding order): BLANK=0, SLIDE_IN=1, HOLD=2, BLINK=3, SLIDE_OUT=4.
- State, `frame_cnt` (frame counter, width sized to the largest frame parameter), `y_offset` and `text_sel` change only on an accepted frame, i.e. `frame_start & ~pause`.
- BLANK: `visible`=0. When `frame_cnt`==BLANK_FRAMES-1, go to SLIDE_IN with `y_offset`=SLIDE_DIST and `frame_cnt`=0. Otherwise increment `frame_cnt`.
- SLIDE_IN: `visible`=1.
  - If `y_offset` ≤ SLIDE_STEP: set `y_offset`=0 (saturate, no underflow) and go to HOLD with `frame_cnt`=0.
  - Else: `y_offset` -= SLIDE_STEP.
- HOLD: `visible`=1, `y_offset`=0. At `frame_cnt`==HOLD_FRAMES-1, go to BLINK (or SLIDE_OUT, see Configuration) with `frame_cnt`=0.
- BLINK: `visible`=~`frame_cnt`[3], so the text toggles every 8 frames starting visible. At `frame_cnt`==BLINK_FRAMES-1, go to SLIDE_OUT with `frame_cnt`=0.
- SLIDE_OUT: `visible`=1.
  - If `y_offset` ≥ SLIDE_DIST-SLIDE_STEP: set `y_offset`=SLIDE_DIST (saturate), go to BLANK, and advance `text_sel` with wrap NUM_TEXTS-1 → 0.
  - Else: `y_offset` += SLIDE_STEP.
- `overlay_active` = `visible` & `text_active[text_sel]`.
- Reset values: state BLANK, `phase`=0, `frame_cnt`=0, `text_sel`=0, `y_offset`=SLIDE_DIST, `visible`=0, `overlay_active`=0.

## Timing
- All state registers update on the clock edge where an accepted `frame_start` is sampled. New values are visible from the next cycle, which is inside vblank, so no mid-frame tearing.
- `overlay_active` is combinational from `text_active` through a mux on the registered `text_sel` and `visible`. Zero added pixel latency. `y_offset` is stable for the whole active frame.
- `rst` together with `frame_start`: reset wins.
- `frame_start` while `pause`=1 is dropped, not queued. Releasing `pause` resumes at the next pulse.
- Reset mid-sequence returns to BLANK with `text_sel`=0 on the next cycle.
- Back-to-back `frame_start` pulses (every cycle) are each accepted. There is no minimum spacing requirement.

## Configuration
- `TEXT_SCHED_BLINK_EN` defined: the BLINK state exists as described.
- Not defined: HOLD transitions directly to SLIDE_OUT, and `phase` never equals 3. `BLINK_FRAMES` is unused.

## Structure
- Package `text_sched_pkg` holds:
  - the phase enum/localparams (BLANK..SLIDE_OUT);
  - the phase width (3);
  - the offset width (9).
- One sub-module, `text_sched_timer`: frame counter with synchronous clear, enable (accepted frame) and terminal-count compare input. The FSM and offset arithmetic stay in the top module.

## Test plan
Unless noted, use BLANK=2, HOLD=3, BLINK=16, SLIDE_DIST=8, SLIDE_STEP=3, NUM_TEXTS=2.
- Reset, then 2 frames: `phase` 0→0→1, `y_offset`=8, `overlay_active`=0 in BLANK even with `text_active`=2'b11.
- Slide-in: successive frames give `y_offset` 8→5→2→0 with `phase`=2 on the third. Slide-out gives 0→3→6→8 with `phase`=0 and `text_sel` 0→1.
- Full cycle twice: `text_sel` wraps 1→0. `overlay_active` follows `text_active[1]` only while `text_sel`=1.
- BLINK (macro on): `overlay_active` high frames 0–7, low frames 8–15 with `text_active` held 1. With the macro off, HOLD→SLIDE_OUT and `phase` never 3.
- `pause`=1 across 5 `frame_start` pulses: all outputs unchanged. `rst` asserted during HOLD together with `frame_start`: next cycle `phase`=0, `y_offset`=8, `text_sel`=0.
